// File: rtl/pipeline_dest_tracker_if.sv
// Hazard-check interface between the decode stage, the hazard detector and
// the destination tracker. The tracker sits on the slave side. The driver of
// the ID-stage fields and the control strobes sits on the master side.
interface pipeline_dest_tracker_if #(
    parameter int unsigned REG_BITS = 5,
    parameter int unsigned CNT_BITS = 16
);
    // ID-stage instruction fields
    logic                id_valid;
    logic [REG_BITS-1:0] id_dest;
    logic                id_wb_en;
    logic                id_mem_r;

    // Pipeline control
    logic                hazard_detected;
    logic                flush;
    logic                freeze;
    logic                id_stall;

    // Stage destination information
    logic [REG_BITS-1:0] exe_dest;
    logic [REG_BITS-1:0] mem_dest;
    logic [REG_BITS-1:0] wb_dest;
    logic                exe_mem_r;
    logic                mem_mem_r;
    logic                exe_wb_en;
    logic                mem_wb_en;
    logic                wb_wb_en;

    // Summary outputs
    logic [31:0]         pending_mask;
    logic [CNT_BITS-1:0] stall_cycles;
    logic [CNT_BITS-1:0] freeze_cycles;

    modport master (
        output id_valid, id_dest, id_wb_en, id_mem_r,
        output hazard_detected, flush, freeze,
        input  id_stall,
        input  exe_dest, mem_dest, wb_dest,
        input  exe_mem_r, mem_mem_r,
        input  exe_wb_en, mem_wb_en, wb_wb_en,
        input  pending_mask, stall_cycles, freeze_cycles
    );

    modport slave (
        input  id_valid, id_dest, id_wb_en, id_mem_r,
        input  hazard_detected, flush, freeze,
        output id_stall,
        output exe_dest, mem_dest, wb_dest,
        output exe_mem_r, mem_mem_r,
        output exe_wb_en, mem_wb_en, wb_wb_en,
        output pending_mask, stall_cycles, freeze_cycles
    );
endinterface

// File: rtl/pipeline_dest_tracker.sv
// Destination-register tracker for the EXE/MEM/WB stages of a 5-stage MIPS
// pipeline. It produces the Exe/Mem destination and load flags for the
// hazard detector and inserts bubbles on its stall request. It holds on
// memory freeze, drops the ID instruction on a branch flush, and reports a
// pending-write mask together with saturating stall and freeze counters.
module pipeline_dest_tracker #(
    parameter int unsigned REG_BITS = 5,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_dest_tracker_if.slave bus
);

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] dest;
        logic                wb_en;
        logic                mem_r;
    } entry_t;

    entry_t exe_q;
    entry_t mem_q;
    entry_t wb_q;
    entry_t id_entry;

    logic                stall_req;
    logic                capture;
    logic [CNT_BITS-1:0] stall_cnt;
    logic [CNT_BITS-1:0] freeze_cnt;

    // One-hot write mask of a stage entry; register 0 never shows as pending.
    function automatic logic [31:0] write_bit(input entry_t e);
        logic [31:0] m;
        m = '0;
        if (e.valid && e.wb_en && (e.dest != '0)) begin
            m[e.dest] = 1'b1;
        end
        return m;
    endfunction

    // Stall/capture decisions. A flushed instruction neither stalls nor
    // enters EXE, so flush masks the hazard request.
    always_comb begin
        stall_req    = bus.hazard_detected & bus.id_valid & ~bus.flush;
        capture      = bus.id_valid & ~bus.flush & ~bus.hazard_detected;
        bus.id_stall = bus.freeze | stall_req;
    end

    // Normalise the ID fields: writes and loads to r0 are stored as no-ops.
    always_comb begin
        id_entry       = '0;
        id_entry.valid = 1'b1;
        id_entry.dest  = bus.id_dest;
        id_entry.wb_en = bus.id_wb_en & (bus.id_dest != '0);
        id_entry.mem_r = bus.id_mem_r & (bus.id_dest != '0);
    end

    // Stage advance. Freeze holds every entry, and a non-captured slot
    // becomes a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_q <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!bus.freeze) begin
            wb_q  <= mem_q;
            mem_q <= exe_q;
            exe_q <= capture ? id_entry : '0;
        end
    end

    // Saturating statistics. Freeze takes priority, so a hazard seen during
    // a freeze is not counted as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            freeze_cnt <= '0;
        end else if (bus.freeze) begin
            if (freeze_cnt != '1) begin
                freeze_cnt <= freeze_cnt + 1'b1;
            end
        end else if (stall_req) begin
            if (stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    // Stage outputs. Fields of a non-valid entry are forced to zero.
    always_comb begin
        bus.exe_dest      = exe_q.valid ? exe_q.dest : '0;
        bus.mem_dest      = mem_q.valid ? mem_q.dest : '0;
        bus.wb_dest       = wb_q.valid  ? wb_q.dest  : '0;
        bus.exe_mem_r     = exe_q.valid & exe_q.mem_r;
        bus.mem_mem_r     = mem_q.valid & mem_q.mem_r;
        bus.exe_wb_en     = exe_q.valid & exe_q.wb_en;
        bus.mem_wb_en     = mem_q.valid & mem_q.wb_en;
        bus.wb_wb_en      = wb_q.valid  & wb_q.wb_en;
        bus.pending_mask  = write_bit(exe_q) | write_bit(mem_q) | write_bit(wb_q);
        bus.stall_cycles  = stall_cnt;
        bus.freeze_cycles = freeze_cnt;
    end

endmodule

// File: tb/tb_pipeline_dest_tracker.sv
// Directed bench for pipeline_dest_tracker. It covers reset, load-use,
// flush priority, freeze, r0/duplicate writers and counter saturation.
// Counters are 4 bits wide here so that saturation is reachable.
module tb_pipeline_dest_tracker;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pipeline_dest_tracker_if #(.REG_BITS(5), .CNT_BITS(4)) bus ();

    pipeline_dest_tracker #(.REG_BITS(5), .CNT_BITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle 2ns past it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [4:0] d, input logic wb, input logic mr,
                         input logic haz, input logic fl, input logic frz);
        bus.id_valid        = v;
        bus.id_dest         = d;
        bus.id_wb_en        = wb;
        bus.id_mem_r        = mr;
        bus.hazard_detected = haz;
        bus.flush           = fl;
        bus.freeze          = frz;
    endtask

    task automatic do_reset();
        drive(0, 5'd0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(0, 5'd0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.exe_dest, bus.mem_dest, bus.wb_dest, bus.exe_mem_r, bus.mem_mem_r,
                       bus.exe_wb_en, bus.mem_wb_en, bus.wb_wb_en, bus.id_stall} !== '0) begin
            failures++; $display("FAIL rst_outputs got nonzero stage outputs exp=0"); end
        checks++; if (bus.pending_mask !== 32'h0) begin
            failures++; $display("FAIL rst_pending got=%0h exp=0", bus.pending_mask); end
        do_reset();
        // Build up some state: r3 in flight, one stall, one freeze.
        drive(1, 5'd3, 1, 0, 0, 0, 0); tick();
        checks++; if (bus.exe_dest !== 5'd3) begin
            failures++; $display("FAIL rst_pre_exe got=%0d exp=3", bus.exe_dest); end
        drive(1, 5'd4, 1, 0, 1, 0, 0); tick();
        drive(0, 5'd0, 0, 0, 0, 0, 1); tick();
        drive(0, 5'd0, 0, 0, 0, 0, 0);
        checks++; if (bus.pending_mask !== 32'h8) begin
            failures++; $display("FAIL rst_pre_mask got=%0h exp=8", bus.pending_mask); end
        checks++; if ({bus.stall_cycles, bus.freeze_cycles} !== 8'h11) begin
            failures++; $display("FAIL rst_pre_cnt got=%0h exp=11", {bus.stall_cycles, bus.freeze_cycles}); end
        // Asynchronous reset mid-cycle.
        #3 rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_dest !== 5'd0) begin
            failures++; $display("FAIL rst_async_mem got=%0d exp=0", bus.mem_dest); end
        checks++; if (bus.pending_mask !== 32'h0) begin
            failures++; $display("FAIL rst_async_mask got=%0h exp=0", bus.pending_mask); end
        checks++; if ({bus.stall_cycles, bus.freeze_cycles} !== 8'h00) begin
            failures++; $display("FAIL rst_async_cnt got=%0h exp=0", {bus.stall_cycles, bus.freeze_cycles}); end
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 5'd5, 1, 1, 0, 0, 0); tick();
        checks++; if ({bus.exe_dest, bus.exe_mem_r} !== {5'd5, 1'b1}) begin
            failures++; $display("FAIL lu_load_exe got=%0d/%0b exp=5/1", bus.exe_dest, bus.exe_mem_r); end
        drive(1, 5'd6, 1, 0, 1, 0, 0);
        #1;
        checks++; if (bus.id_stall !== 1'b1) begin
            failures++; $display("FAIL lu_stall got=%0b exp=1", bus.id_stall); end
        tick();
        checks++; if ({bus.exe_dest, bus.exe_mem_r} !== {5'd0, 1'b0}) begin
            failures++; $display("FAIL lu_bubble got=%0d/%0b exp=0/0", bus.exe_dest, bus.exe_mem_r); end
        checks++; if ({bus.mem_dest, bus.mem_mem_r} !== {5'd5, 1'b1}) begin
            failures++; $display("FAIL lu_mem got=%0d/%0b exp=5/1", bus.mem_dest, bus.mem_mem_r); end
        checks++; if (bus.stall_cycles !== 4'd1) begin
            failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", bus.stall_cycles); end
        drive(1, 5'd6, 1, 0, 0, 0, 0);
        #1;
        checks++; if (bus.id_stall !== 1'b0) begin
            failures++; $display("FAIL lu_nostall got=%0b exp=0", bus.id_stall); end
        tick();
        checks++; if ({bus.exe_dest, bus.wb_dest, bus.stall_cycles} !== {5'd6, 5'd5, 4'd1}) begin
            failures++; $display("FAIL lu_proceed got=%0d/%0d/%0d exp=6/5/1", bus.exe_dest, bus.wb_dest, bus.stall_cycles); end
        drive(0, 5'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 5'd7, 1, 0, 1, 1, 0);
        #1;
        checks++; if (bus.id_stall !== 1'b0) begin
            failures++; $display("FAIL fl_stall got=%0b exp=0", bus.id_stall); end
        tick();
        checks++; if ({bus.exe_dest, bus.exe_wb_en, bus.pending_mask} !== {5'd0, 1'b0, 32'h0}) begin
            failures++; $display("FAIL fl_bubble got=%0d/%0b/%0h exp=0/0/0", bus.exe_dest, bus.exe_wb_en, bus.pending_mask); end
        checks++; if (bus.stall_cycles !== 4'd0) begin
            failures++; $display("FAIL fl_stall_cnt got=%0d exp=0", bus.stall_cycles); end
        drive(1, 5'd7, 1, 0, 0, 1, 0); tick();
        checks++; if (bus.exe_dest !== 5'd0) begin
            failures++; $display("FAIL fl_nohaz_exe got=%0d exp=0", bus.exe_dest); end
        drive(0, 5'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_freeze();
        do_reset();
        drive(1, 5'd6, 1, 0, 0, 0, 0); tick();
        drive(1, 5'd4, 1, 0, 0, 0, 0); tick();
        drive(1, 5'd3, 1, 0, 0, 0, 0); tick();
        checks++; if ({bus.exe_dest, bus.mem_dest, bus.wb_dest} !== {5'd3, 5'd4, 5'd6}) begin
            failures++; $display("FAIL fz_fill got=%0d/%0d/%0d exp=3/4/6", bus.exe_dest, bus.mem_dest, bus.wb_dest); end
        checks++; if (bus.pending_mask !== 32'h58) begin
            failures++; $display("FAIL fz_mask got=%0h exp=58", bus.pending_mask); end
        // Freeze with a concurrent hazard: freeze wins.
        drive(1, 5'd8, 1, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.id_stall !== 1'b1) begin
                failures++; $display("FAIL fz_stall_%0d got=%0b exp=1", i, bus.id_stall); end
            tick();
            checks++; if ({bus.exe_dest, bus.mem_dest, bus.wb_dest} !== {5'd3, 5'd4, 5'd6}) begin
                failures++; $display("FAIL fz_hold_%0d got=%0d/%0d/%0d exp=3/4/6", i, bus.exe_dest, bus.mem_dest, bus.wb_dest); end
        end
        checks++; if ({bus.freeze_cycles, bus.stall_cycles} !== {4'd4, 4'd0}) begin
            failures++; $display("FAIL fz_cnt got=%0d/%0d exp=4/0", bus.freeze_cycles, bus.stall_cycles); end
        drive(0, 5'd0, 0, 0, 0, 0, 0); tick();
        checks++; if ({bus.exe_dest, bus.mem_dest, bus.wb_dest} !== {5'd0, 5'd3, 5'd4}) begin
            failures++; $display("FAIL fz_rel1 got=%0d/%0d/%0d exp=0/3/4", bus.exe_dest, bus.mem_dest, bus.wb_dest); end
        tick();
        checks++; if ({bus.exe_dest, bus.mem_dest, bus.wb_dest} !== {5'd0, 5'd0, 5'd3}) begin
            failures++; $display("FAIL fz_rel2 got=%0d/%0d/%0d exp=0/0/3", bus.exe_dest, bus.mem_dest, bus.wb_dest); end
    endtask

    task automatic test_r0_dup();
        do_reset();
        drive(1, 5'd0, 1, 1, 0, 0, 0); tick();
        checks++; if ({bus.pending_mask, bus.exe_wb_en, bus.exe_mem_r} !== {32'h0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL r0_norm got=%0h/%0b/%0b exp=0/0/0", bus.pending_mask, bus.exe_wb_en, bus.exe_mem_r); end
        drive(1, 5'd10, 0, 0, 0, 0, 0); tick();
        checks++; if ({bus.exe_dest, bus.pending_mask} !== {5'd10, 32'h0}) begin
            failures++; $display("FAIL nowb_mask got=%0d/%0h exp=10/0", bus.exe_dest, bus.pending_mask); end
        drive(1, 5'd9, 1, 0, 0, 0, 0); tick();
        tick();
        drive(0, 5'd0, 0, 0, 0, 0, 0);
        checks++; if (bus.pending_mask !== 32'h200) begin
            failures++; $display("FAIL dup_c2 got=%0h exp=200", bus.pending_mask); end
        tick();
        checks++; if (bus.pending_mask !== 32'h200) begin
            failures++; $display("FAIL dup_c3 got=%0h exp=200", bus.pending_mask); end
        tick();
        checks++; if ({bus.pending_mask, bus.wb_dest} !== {32'h200, 5'd9}) begin
            failures++; $display("FAIL dup_c4 got=%0h/%0d exp=200/9", bus.pending_mask, bus.wb_dest); end
        tick();
        checks++; if (bus.pending_mask !== 32'h0) begin
            failures++; $display("FAIL dup_clear got=%0h exp=0", bus.pending_mask); end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1, 5'd2, 1, 0, 1, 0, 0);
        repeat (14) tick();
        checks++; if (bus.stall_cycles !== 4'd14) begin
            failures++; $display("FAIL sat_14 got=%0d exp=14", bus.stall_cycles); end
        tick();
        checks++; if (bus.stall_cycles !== 4'd15) begin
            failures++; $display("FAIL sat_15 got=%0d exp=15", bus.stall_cycles); end
        repeat (5) tick();
        checks++; if ({bus.stall_cycles, bus.exe_dest} !== {4'd15, 5'd0}) begin
            failures++; $display("FAIL sat_20 got=%0d/%0d exp=15/0", bus.stall_cycles, bus.exe_dest); end
        drive(0, 5'd0, 0, 0, 0, 0, 1);
        repeat (17) tick();
        checks++; if ({bus.freeze_cycles, bus.stall_cycles} !== {4'd15, 4'd15}) begin
            failures++; $display("FAIL sat_freeze got=%0d/%0d exp=15/15", bus.freeze_cycles, bus.stall_cycles); end
        drive(0, 5'd0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(0, 5'd0, 0, 0, 0, 0, 0);
        test_reset();
        test_load_use();
        test_flush();
        test_freeze();
        test_r0_dup();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
